// File: rtl/dual_issue_pkg.sv
// Shared types and constants for the dual-issue scheduler and its dependency checker.
package dual_issue_pkg;

   typedef enum logic {DUAL = 1'b0, HOLD2 = 1'b1} sched_state_t;

   localparam int REG_AW_DEFAULT = 5;
   localparam logic [REG_AW_DEFAULT-1:0] X0 = '0;

endpackage

// File: rtl/pair_dep_check.sv
// Combinational intra-pair dependency detect: does the older (P1) instruction write a
// register that the younger (P2) instruction reads or also writes? Reusable by forwarding.
module pair_dep_check
   import dual_issue_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEFAULT
) (
   input  logic              i_valid1,
   input  logic              i_valid2,
   input  logic              i_reg_write1,
   input  logic              i_reg_write2,
   input  logic [REG_AW-1:0] i_rd1,
   input  logic [REG_AW-1:0] i_rd2,
   input  logic [REG_AW-1:0] i_rs1_2,
   input  logic [REG_AW-1:0] i_rs2_2,
   output logic              o_dep
);

   logic w_writer;
   logic w_match;

   // x0 is hardwired to zero, so a write to it can never feed P2
   assign w_writer = i_valid1 & i_valid2 & i_reg_write1 & (i_rd1 != REG_AW'(X0));
   assign w_match  = (i_rd1 == i_rs1_2) |
                     (i_rd1 == i_rs2_2) |
                     (i_reg_write2 & (i_rd1 == i_rd2));
   assign o_dep    = w_writer & w_match;

endmodule

// File: rtl/dual_issue_scheduler.sv
// Two-wide issue sequencer: serialises a dependent Decode pair (P2 held, then P1 held).
// Optional serialisation counter enabled by defining HAZARD_CNT_EN.
module dual_issue_scheduler
   import dual_issue_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEFAULT
`ifdef HAZARD_CNT_EN
 , parameter int CNT_W  = 32
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ValidD1,
   input  logic              ValidD2,
   input  logic              RegWriteD1,
   input  logic              RegWriteD2,
   input  logic [REG_AW-1:0] RdD1,
   input  logic [REG_AW-1:0] RdD2,
   input  logic [REG_AW-1:0] Rs1D2,
   input  logic [REG_AW-1:0] Rs2D2,
   input  logic              StallIn,
   input  logic              FlushD,
   output logic              StallPipeline1,
   output logic              StallPipeline2,
   output logic              RedirectF
`ifdef HAZARD_CNT_EN
 , output logic [CNT_W-1:0]  SerialCount
`endif
);

   sched_state_t r_state;
   sched_state_t w_next_state;
   logic         w_dep;
   logic         w_stall1;
   logic         w_stall2;
   logic         w_redirect;
   logic         w_enter_hold;

   pair_dep_check #(.REG_AW(REG_AW)) u_dep (
      .i_valid1     (ValidD1),
      .i_valid2     (ValidD2),
      .i_reg_write1 (RegWriteD1),
      .i_reg_write2 (RegWriteD2),
      .i_rd1        (RdD1),
      .i_rd2        (RdD2),
      .i_rs1_2      (Rs1D2),
      .i_rs2_2      (Rs2D2),
      .o_dep        (w_dep)
   );

   // NOTE: non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= DUAL;
      else     r_state <= w_next_state;
   end

   // NOTE: every output gets a default first, so no path through the case infers a latch.
   always_comb begin
      w_next_state = r_state;
      w_stall1     = 1'b0;
      w_stall2     = 1'b0;
      w_redirect   = 1'b0;
      w_enter_hold = 1'b0;
      case (r_state)
         DUAL: begin
            w_stall2 = w_dep & ~FlushD;
            if (w_dep & ~FlushD & ~StallIn) begin
               w_next_state = HOLD2;
               w_enter_hold = 1'b1;
            end
         end
         HOLD2: begin
            // P2 is already ordered behind P1; dep is deliberately not re-checked here
            w_stall1     = ~FlushD;
            w_redirect   = ~FlushD;
            w_next_state = (StallIn & ~FlushD) ? HOLD2 : DUAL;
         end
         default: w_next_state = DUAL;
      endcase
   end

   assign StallPipeline1 = w_stall1   & ~rst;
   assign StallPipeline2 = w_stall2   & ~rst;
   assign RedirectF      = w_redirect & ~rst;

`ifdef HAZARD_CNT_EN
   logic [CNT_W-1:0] r_serial_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               r_serial_count <= '0;
      else if (w_enter_hold) r_serial_count <= r_serial_count + CNT_W'(1);
   end

   assign SerialCount = r_serial_count;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler; also covers SerialCount when HAZARD_CNT_EN is defined.
module tb_dual_issue_scheduler;

   typedef struct packed {
      logic       v1;
      logic       v2;
      logic       rw1;
      logic       rw2;
      logic [4:0] rd1;
      logic [4:0] rd2;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } pair_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       ValidD1, ValidD2, RegWriteD1, RegWriteD2;
   logic [4:0] RdD1, RdD2, Rs1D2, Rs2D2;
   logic       StallIn, FlushD;
   logic       StallPipeline1, StallPipeline2, RedirectF;
   logic [2:0] obs;
   int         n_pass  = 0;
   int         n_total = 0;
`ifdef HAZARD_CNT_EN
   logic [31:0] SerialCount;
   logic [31:0] exp_cnt = '0;
`endif

   always #5 clk = ~clk;

   assign obs = {StallPipeline1, StallPipeline2, RedirectF};

   dual_issue_scheduler dut (
      .clk            (clk),
      .rst            (rst),
      .ValidD1        (ValidD1),
      .ValidD2        (ValidD2),
      .RegWriteD1     (RegWriteD1),
      .RegWriteD2     (RegWriteD2),
      .RdD1           (RdD1),
      .RdD2           (RdD2),
      .Rs1D2          (Rs1D2),
      .Rs2D2          (Rs2D2),
      .StallIn        (StallIn),
      .FlushD         (FlushD),
      .StallPipeline1 (StallPipeline1),
      .StallPipeline2 (StallPipeline2),
      .RedirectF      (RedirectF)
`ifdef HAZARD_CNT_EN
    , .SerialCount    (SerialCount)
`endif
   );

   function automatic pair_t mk(input logic v1, v2, rw1, rw2,
                                input logic [4:0] rd1, rd2, rs1, rs2);
      mk = {v1, v2, rw1, rw2, rd1, rd2, rs1, rs2};
   endfunction

   // Canonical RAW pair: P1 writes x5, P2 reads x5 on rs2.
   localparam pair_t DEP_RAW = {1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd1, 5'd5};
   localparam pair_t IDLE    = '0;

   task automatic set_pair(input pair_t p);
      ValidD1 = p.v1;  ValidD2 = p.v2;  RegWriteD1 = p.rw1; RegWriteD2 = p.rw2;
      RdD1    = p.rd1; RdD2    = p.rd2; Rs1D2      = p.rs1; Rs2D2      = p.rs2;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_pair(DEP_RAW);
      StallIn = 1'b0;
      FlushD  = 1'b0;
      #2;
      n_total++;
      if (obs !== 3'b000) $display("FAIL reset_outputs: got %b want 000", obs);
      else n_pass++;
`ifdef HAZARD_CNT_EN
      n_total++;
      if (SerialCount !== 32'd0) $display("FAIL reset_count: got %0d want 0", SerialCount);
      else n_pass++;
`endif
      next_cycle();
      n_total++;
      if (obs !== 3'b000) $display("FAIL reset_held_edge: got %b want 000", obs);
      else n_pass++;
      rst = 1'b0;
      set_pair(IDLE);
      @(negedge clk);
      n_total++;
      if (obs !== 3'b000) $display("FAIL reset_release_idle: got %b want 000", obs);
      else n_pass++;
      next_cycle();
   endtask

   task automatic test_independent();
      set_pair(mk(1, 1, 1, 1, 5'd5, 5'd8, 5'd6, 5'd7));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_total++;
         if (obs !== 3'b000) $display("FAIL independent cycle %0d: got %b want 000", i, obs);
         else n_pass++;
         next_cycle();
      end
      set_pair(IDLE);
   endtask

   task automatic test_raw();
      logic [2:0] exp_o [3] = '{3'b010, 3'b101, 3'b000};
      set_pair(DEP_RAW);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) set_pair(IDLE);
         @(negedge clk);
         n_total++;
         if (obs !== exp_o[i]) $display("FAIL raw cycle %0d: got %b want %b", i, obs, exp_o[i]);
         else n_pass++;
         next_cycle();
      end
`ifdef HAZARD_CNT_EN
      exp_cnt = exp_cnt + 32'd1;
      n_total++;
      if (SerialCount !== exp_cnt) $display("FAIL raw_count: got %0d want %0d", SerialCount, exp_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_o [5] = '{3'b010, 3'b101, 3'b010, 3'b101, 3'b000};
      // RAW through rs1 this time
      set_pair(mk(1, 1, 1, 0, 5'd7, 5'd3, 5'd7, 5'd2));
      for (int i = 0; i < 5; i++) begin
         if (i == 4) set_pair(IDLE);
         @(negedge clk);
         n_total++;
         if (obs !== exp_o[i]) $display("FAIL b2b cycle %0d: got %b want %b", i, obs, exp_o[i]);
         else n_pass++;
         next_cycle();
      end
`ifdef HAZARD_CNT_EN
      exp_cnt = exp_cnt + 32'd2;
      n_total++;
      if (SerialCount !== exp_cnt) $display("FAIL b2b_count: got %0d want %0d", SerialCount, exp_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_x0_invalid();
      pair_t      quiet [5];
      logic [2:0] exp_w [3] = '{3'b010, 3'b101, 3'b000};
      quiet[0] = mk(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 5'd3);  // rd1 = x0
      quiet[1] = mk(1, 0, 1, 0, 5'd5, 5'd0, 5'd5, 5'd5);  // P2 invalid
      quiet[2] = mk(0, 1, 1, 0, 5'd5, 5'd0, 5'd5, 5'd5);  // P1 invalid
      quiet[3] = mk(1, 1, 0, 0, 5'd5, 5'd0, 5'd5, 5'd5);  // P1 does not write
      quiet[4] = mk(1, 1, 1, 0, 5'd9, 5'd9, 5'd1, 5'd2);  // same rd but P2 does not write
      for (int i = 0; i < 5; i++) begin
         set_pair(quiet[i]);
         @(negedge clk);
         n_total++;
         if (obs !== 3'b000) $display("FAIL nodep case %0d: got %b want 000", i, obs);
         else n_pass++;
         next_cycle();
      end
      set_pair(mk(1, 1, 1, 1, 5'd9, 5'd9, 5'd1, 5'd2));  // WAW
      for (int i = 0; i < 3; i++) begin
         if (i == 2) set_pair(IDLE);
         @(negedge clk);
         n_total++;
         if (obs !== exp_w[i]) $display("FAIL waw cycle %0d: got %b want %b", i, obs, exp_w[i]);
         else n_pass++;
         next_cycle();
      end
`ifdef HAZARD_CNT_EN
      exp_cnt = exp_cnt + 32'd1;
      n_total++;
      if (SerialCount !== exp_cnt) $display("FAIL waw_count: got %0d want %0d", SerialCount, exp_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_stall_in();
      logic       stall_seq [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [2:0] exp_o     [8] = '{3'b010, 3'b010, 3'b010, 3'b010,
                                    3'b101, 3'b101, 3'b101, 3'b000};
      set_pair(DEP_RAW);
      for (int i = 0; i < 8; i++) begin
         StallIn = stall_seq[i];
         if (i == 7) set_pair(IDLE);
         @(negedge clk);
         n_total++;
         if (obs !== exp_o[i]) $display("FAIL stallin cycle %0d: got %b want %b", i, obs, exp_o[i]);
         else n_pass++;
`ifdef HAZARD_CNT_EN
         if (i == 3) begin
            n_total++;
            if (SerialCount !== exp_cnt)
               $display("FAIL stallin_frozen_count: got %0d want %0d", SerialCount, exp_cnt);
            else n_pass++;
         end
`endif
         next_cycle();
      end
      StallIn = 1'b0;
`ifdef HAZARD_CNT_EN
      exp_cnt = exp_cnt + 32'd1;
      n_total++;
      if (SerialCount !== exp_cnt) $display("FAIL stallin_count: got %0d want %0d", SerialCount, exp_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_flush();
      logic       flush_seq [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic       stall_seq [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [2:0] exp_o     [6] = '{3'b010, 3'b000, 3'b000, 3'b010, 3'b101, 3'b000};
      set_pair(DEP_RAW);
      for (int i = 0; i < 6; i++) begin
         FlushD  = flush_seq[i];
         StallIn = stall_seq[i];
         if (i >= 4) set_pair(IDLE);
         @(negedge clk);
         n_total++;
         if (obs !== exp_o[i]) $display("FAIL flush cycle %0d: got %b want %b", i, obs, exp_o[i]);
         else n_pass++;
         next_cycle();
      end
      FlushD  = 1'b0;
      StallIn = 1'b0;
`ifdef HAZARD_CNT_EN
      exp_cnt = exp_cnt + 32'd2;
      n_total++;
      if (SerialCount !== exp_cnt) $display("FAIL flush_count: got %0d want %0d", SerialCount, exp_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_async_reset();
      set_pair(DEP_RAW);
      next_cycle();
      @(negedge clk);
      n_total++;
      if (obs !== 3'b101) $display("FAIL areset_in_hold2: got %b want 101", obs);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_total++;
      if (obs !== 3'b000) $display("FAIL areset_immediate: got %b want 000", obs);
      else n_pass++;
`ifdef HAZARD_CNT_EN
      exp_cnt = '0;
      n_total++;
      if (SerialCount !== exp_cnt) $display("FAIL areset_count: got %0d want 0", SerialCount);
      else n_pass++;
`endif
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if (obs !== 3'b010) $display("FAIL areset_state_dual: got %b want 010", obs);
      else n_pass++;
      set_pair(IDLE);
      next_cycle();
      n_total++;
      if (obs !== 3'b000) $display("FAIL areset_after: got %b want 000", obs);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_independent();
      test_raw();
      test_back_to_back();
      test_x0_invalid();
      test_stall_in();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
